breg_wb: RTL

Write-back sequencer driving the single write port of the 16-entry banked register file. Accepts write requests from execution units over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and drains them in order onto the register file's write port (w, y, wa, wval, mask). It also answers a combinational scoreboard query, so issue logic can stall reads of registers with writes still in flight. The query accounts for the register file's low-bank mirroring: a write to r0–r7 also updates r8–r15.

---
 rtl/breg_wb.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/breg_wb.sv
// -----------------------------------------------------------------------------
// breg_wb : write-back sequencer for the 16-entry banked register file.
//
// Execution units hand write requests in over a valid/ready handshake. The
// requests are buffered in a DEPTH-entry circular FIFO and drained strictly in
// order onto the register file's single write port. XOR writes depend on
// order, so entries are never merged or reordered.
//
// A combinational scoreboard query (q_ra -> q_busy) reports whether any
// pending write will modify register q_ra. The register file mirrors the low
// bank, so a write to r0..r7 also updates r8..r15. The query takes that into
// account.
//
// Optional feature macro: BREG_WB_BYPASS_EN
//   defined   : an incoming request that finds the FIFO empty while the port is
//               free drives the write port in the same cycle and is not stored.
//               q_busy also matches that request.
//   undefined : every request passes through the FIFO. The write port fields
//               come straight from storage registers.
//
// Word width comes from `BITNESS (commons.sv). `WORD denotes [`BITNESS-1:0].
// Both macros get local fallback definitions so the file also builds on its
// own.
//
// Parameters:
//   DEPTH     FIFO entries; a power of two, at least 2.
//
// Ports:
//   clk       clock
//   rst       reset, asynchronous, active-high
//   in_valid  request valid
//   in_ready  FIFO can accept a request (level < DEPTH)
//   in_y      1 = overwrite, 0 = XOR into the current value
//   in_wa     target register
//   in_val    write data
//   in_mask   bit write mask
//   hold      register file write port unavailable this cycle
//   w         write strobe to the register file
//   y         overwrite/XOR select of the entry being written
//   wa        write address of the entry being written
//   wval      write data of the entry being written
//   mask      write mask of the entry being written
//   q_ra      scoreboard query register
//   q_busy    a pending write will modify q_ra
//   level     number of entries currently held in the FIFO
//
// Handshake: a request transfers at a rising edge of clk where in_valid and
// in_ready are both high. in_ready depends only on the registered fill level,
// never on whether an entry pops in the same cycle. The sender may therefore
// wait on in_ready without creating a combinational loop. A request that is
// not accepted must stay stable until it is accepted. On the write side there
// is no back-pressure beyond hold. Whenever w is high the register file takes
// the write, and the head entry retires at that edge.
// -----------------------------------------------------------------------------

`ifndef BITNESS
`define BITNESS 8
`endif

`ifndef WORD
`define WORD [`BITNESS-1:0]
`endif

module breg_wb #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   // request side
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_y,
   input  logic [3:0]                 in_wa,
   input  logic `WORD                 in_val,
   input  logic `WORD                 in_mask,
   // register file write port
   input  logic                       hold,
   output logic                       w,
   output logic                       y,
   output logic [3:0]                 wa,
   output logic `WORD                 wval,
   output logic `WORD                 mask,
   // scoreboard query
   input  logic [3:0]                 q_ra,
   output logic                       q_busy,
   // status
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // ---------------------------------------------------------------------------
   // Storage and pointers
   // ---------------------------------------------------------------------------
   logic              ent_y    [DEPTH];
   logic [3:0]        ent_wa   [DEPTH];
   logic `WORD        ent_val  [DEPTH];
   logic `WORD        ent_mask [DEPTH];

   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [LW-1:0]     count;

   logic              fifo_nonempty;
   logic              fifo_w;      // head entry is being written this cycle
   logic              push;        // request enters the FIFO at this edge
   logic              pop;         // head entry retires at this edge
   logic              byp;         // request goes straight to the write port
   logic [DEPTH-1:0]  slot_valid;  // physical slot currently holds an entry
   logic              fifo_busy;   // scoreboard hit among stored entries

   assign fifo_nonempty = (count != '0);
   assign in_ready      = (count < LW'(DEPTH));
   assign fifo_w        = fifo_nonempty && !hold;
   assign pop           = fifo_w;

`ifdef BREG_WB_BYPASS_EN
   // The FIFO is empty, so no stored write can be older than this request.
   // Sending it straight through keeps the ordering intact.
   assign byp = !fifo_nonempty && !hold && in_valid;
`else
   assign byp = 1'b0;
`endif

   // A bypassed request is consumed at this edge without being stored.
   assign push = in_valid && in_ready && !byp;

   // ---------------------------------------------------------------------------
   // Pointer and level bookkeeping
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         // A push and a pop in the same cycle leave the level unchanged.
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Entry storage. Cleared on reset so the head fields never carry X.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_y[i]    <= 1'b0;
            ent_wa[i]   <= '0;
            ent_val[i]  <= '0;
            ent_mask[i] <= '0;
         end
      end else if (push) begin
         ent_y[wr_ptr]    <= in_y;
         ent_wa[wr_ptr]   <= in_wa;
         ent_val[wr_ptr]  <= in_val;
         ent_mask[wr_ptr] <= in_mask;
      end
   end

   // ---------------------------------------------------------------------------
   // Write port
   // ---------------------------------------------------------------------------
`ifdef BREG_WB_BYPASS_EN
   assign w    = fifo_w || byp;
   assign y    = byp ? in_y    : ent_y[rd_ptr];
   assign wa   = byp ? in_wa   : ent_wa[rd_ptr];
   assign wval = byp ? in_val  : ent_val[rd_ptr];
   assign mask = byp ? in_mask : ent_mask[rd_ptr];
`else
   assign w    = fifo_w;
   assign y    = ent_y[rd_ptr];
   assign wa   = ent_wa[rd_ptr];
   assign wval = ent_val[rd_ptr];
   assign mask = ent_mask[rd_ptr];
`endif

   assign level = count;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------

   // A write to r0..r7 also lands in its mirror r8..r15.
   function automatic logic wa_hits(input logic [3:0] ewa, input logic [3:0] ra);
      return (ewa == ra) || (!ewa[3] && ({1'b1, ewa[2:0]} == ra));
   endfunction

   // A slot is occupied when its distance from the read pointer (modulo DEPTH)
   // is below the fill level. This also covers the full case, where the two
   // pointers are equal.
   always_comb begin
      slot_valid = '0;
      for (int j = 0; j < DEPTH; j++) begin
         slot_valid[j] = ({1'b0, AW'(AW'(j) - rd_ptr)} < count);
      end
   end

   // The head stays visible while it is being strobed. It clears only after
   // the edge at which it retires.
   always_comb begin
      fifo_busy = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         if (slot_valid[j] && wa_hits(ent_wa[j], q_ra)) fifo_busy = 1'b1;
      end
   end

`ifdef BREG_WB_BYPASS_EN
   assign q_busy = fifo_busy || (byp && wa_hits(in_wa, q_ra));
`else
   assign q_busy = fifo_busy;
`endif

endmodule
